// File: rtl/sha256_xmss_core.sv
// SHA-256 core for XMSS hashing of 768- or 1024-bit messages.
// One compression round per clock, 16-word sliding schedule window.
module sha256_xmss_core #(
  parameter int KEY_LEN = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hash_start,
  input  logic [1023:0]      hash_data_in,
  input  logic               message_length,
  output logic               hash_done,
  output logic [KEY_LEN-1:0] hash_data_out,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND, UPDATE, DONE
  } state_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]}
         ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]}
         ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]}
         ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]}
         ^ {10'b0, x[31:10]};
  endfunction

  state_t state, state_n;

  logic [1023:0]      msg;
  logic               len;
  logic [1:0]         blk;
  logic [5:0]         rnd;
  logic [31:0]        w  [16];
  logic [31:0]        v  [8];
  logic [31:0]        hv [8];
  logic [KEY_LEN-1:0] dout;

  logic        last_blk;
  logic [511:0] cur_blk;
  logic [31:0] t1, t2, w_new;
  logic [31:0] hs [8];

  assign last_blk      = (blk == (len ? 2'd2 : 2'd1));
  assign hash_data_out = dout;

  // Padded block selection; the length word is fixed per mode.
  always_comb begin
    cur_blk = {1'b1, 447'b0, 64'd1024};
    unique case (blk)
      2'd0: cur_blk = msg[1023:512];
      2'd1: cur_blk = len ? msg[511:0]
                          : {msg[511:256], 1'b1,
                             191'b0, 64'd768};
      default: ;
    endcase
  end

  // Round function, schedule extension and chaining sums.
  always_comb begin
    t1 = v[7] + bsig1(v[4])
       + ((v[4] & v[5]) ^ (~v[4] & v[6]))
       + K[rnd] + w[0];
    t2 = bsig0(v[0])
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    for (int i = 0; i < 8; i++) hs[i] = hv[i] + v[i];
  end

  // Next state and status outputs.
  always_comb begin
    state_n   = state;
    hash_done = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (hash_start) state_n = LOAD;
      LOAD: begin
        busy    = 1'b1;
        state_n = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd == 6'd63) state_n = UPDATE;
      end
      UPDATE: begin
        busy    = 1'b1;
        state_n = last_blk ? DONE : LOAD;
      end
      DONE: begin
        hash_done = 1'b1;
        state_n   = hash_start ? LOAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath: capture, load, compress, chain, publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg  <= '0;
      len  <= 1'b0;
      blk  <= 2'd0;
      rnd  <= 6'd0;
      dout <= '0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
      for (int i = 0; i < 8; i++) begin
        v[i]  <= '0;
        hv[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (hash_start) begin
            msg <= hash_data_in;
            len <= message_length;
            blk <= 2'd0;
            for (int i = 0; i < 8; i++) hv[i] <= IV[i];
          end
        end
        LOAD: begin
          for (int i = 0; i < 8; i++) v[i] <= hv[i];
          for (int j = 0; j < 16; j++)
            w[j] <= cur_blk[511-32*j -: 32];
        end
        ROUND: begin
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          for (int j = 0; j < 15; j++) w[j] <= w[j+1];
          w[15] <= w_new;
          rnd   <= rnd + 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hv[i] <= hs[i];
          blk <= blk + 2'd1;
          if (last_blk)
            dout <= {hs[0], hs[1], hs[2], hs[3],
                     hs[4], hs[5], hs[6], hs[7]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_xmss_core.sv
// Directed bench for sha256_xmss_core against a
// behavioural SHA-256 with generic padding.
module tb_sha256_xmss_core;

  logic          clk;
  logic          reset;
  logic          hash_start;
  logic [1023:0] hash_data_in;
  logic          message_length;
  logic          hash_done;
  logic [255:0]  hash_data_out;
  logic          busy;

  int n_chk, n_fail;
  int cyc, t0, done_cnt;

  sha256_xmss_core #(.KEY_LEN(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .hash_start     (hash_start),
    .hash_data_in   (hash_data_in),
    .message_length (message_length),
    .hash_done      (hash_done),
    .hash_data_out  (hash_data_out),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (hash_done) done_cnt <= done_cnt + 1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] HT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message is m[1023 -: nbits]; padding done generically.
  function automatic logic [255:0] ref_sha(
    input logic [1023:0] m, input int nbits);
    logic [1535:0] b;
    logic [31:0] h [8];
    logic [31:0] x [8];
    logic [31:0] wt [64];
    logic [31:0] s0, s1, e1, a0, ch, mj, u1, u2;
    int nb;
    b = {m, 512'b0};
    for (int i = 0; i < 1536 - nbits; i++) b[i] = 1'b0;
    b[1535-nbits] = 1'b1;
    nb = (nbits + 65 + 511) / 512;
    b[1536-512*nb +: 64] = 64'(nbits);
    for (int i = 0; i < 8; i++) h[i] = HT[i];
    for (int bk = 0; bk < nb; bk++) begin
      for (int t = 0; t < 16; t++)
        wt[t] = b[1535-512*bk-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
        s0 = rotr(wt[t-15], 7) ^ rotr(wt[t-15], 18)
           ^ (wt[t-15] >> 3);
        s1 = rotr(wt[t-2], 17) ^ rotr(wt[t-2], 19)
           ^ (wt[t-2] >> 10);
        wt[t] = wt[t-16] + s0 + wt[t-7] + s1;
      end
      for (int i = 0; i < 8; i++) x[i] = h[i];
      for (int t = 0; t < 64; t++) begin
        e1 = rotr(x[4], 6) ^ rotr(x[4], 11) ^ rotr(x[4], 25);
        ch = (x[4] & x[5]) ^ (~x[4] & x[6]);
        u1 = x[7] + e1 + ch + KT[t] + wt[t];
        a0 = rotr(x[0], 2) ^ rotr(x[0], 13) ^ rotr(x[0], 22);
        mj = (x[0] & x[1]) ^ (x[0] & x[2]) ^ (x[1] & x[2]);
        u2 = a0 + mj;
        x[7] = x[6]; x[6] = x[5]; x[5] = x[4];
        x[4] = x[3] + u1;
        x[3] = x[2]; x[2] = x[1]; x[1] = x[0];
        x[0] = u1 + u2;
      end
      for (int i = 0; i < 8; i++) h[i] = h[i] + x[i];
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] exp_dig(
    input logic [1023:0] m, input logic l);
    return ref_sha(m, l ? 1024 : 768);
  endfunction

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [1023:0] m,
                           input logic l);
    hash_data_in   = m;
    message_length = l;
    hash_start     = 1'b1;
    t0             = cyc;
    @(posedge clk);
    #1;
    hash_start     = 1'b0;
    hash_data_in   = {32{$urandom}};
    message_length = ~l;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hash_done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  logic [1023:0] m_zero, m_xmss, m_alt, m_ch [4];
  logic [255:0]  d1;
  int lat, tfirst, hold_bad, dc0, c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; t0 = 0; done_cnt = 0;
    reset = 1'b1; hash_start = 1'b0;
    hash_data_in = '0; message_length = 1'b0;
    m_zero = '0;
    m_xmss = {256'd1, {32{8'hAA}},
              256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007,
              256'd0};
    m_alt  = {32{32'hdeadbeef}};
    m_ch[0] = {32{32'h01234567}};
    m_ch[1] = {32{32'h89abcdef}};
    m_ch[2] = {32{32'h0f1e2d3c}};
    m_ch[3] = {32{32'h5a5a0ff0}};

    check("model_abc", ref_sha({24'h616263, 1000'b0}, 24),
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    hash_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", hash_done, 0);
    check("rst_dout", hash_data_out, 0);
    @(posedge clk); #1;
    reset = 1'b0; hash_start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // all-zero 768-bit message
    @(posedge clk); #1;
    start_req(m_zero, 1'b0);
    @(negedge clk);
    check("zero_busy_c1", busy, 1);
    wait_done(300, lat);
    check("zero_lat", lat, 133);
    check("zero_dig", hash_data_out, exp_dig(m_zero, 1'b0));
    check("zero_busy_done", busy, 0);
    @(negedge clk);
    check("zero_done_width", hash_done, 0);

    // XMSS-shaped 1024-bit message
    @(posedge clk); #1;
    start_req(m_xmss, 1'b1);
    wait_done(400, lat);
    check("xmss_lat", lat, 199);
    check("xmss_dig", hash_data_out, exp_dig(m_xmss, 1'b1));
    @(negedge clk);
    check("xmss_done_width", hash_done, 0);
    check("xmss_hold_idle", hash_data_out,
          exp_dig(m_xmss, 1'b1));

    // starts while busy are ignored
    @(posedge clk); #1;
    dc0 = done_cnt;
    start_req(m_alt, 1'b0);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hash_done) begin
        lat = cyc - t0;
        break;
      end
      c = cyc - t0;
      if (c == 10 || c == 50 || c == 100) begin
        hash_start     = 1'b1;
        hash_data_in   = m_zero;
        message_length = 1'b1;
        @(posedge clk); #1;
        hash_start = 1'b0;
      end
    end
    check("ign_lat", lat, 133);
    check("ign_dig", hash_data_out, exp_dig(m_alt, 1'b0));
    repeat (5) @(posedge clk);
    #1;
    check("ign_done_cnt", done_cnt - dc0, 1);

    // back-to-back: second start in the DONE cycle
    start_req(m_zero, 1'b0);
    tfirst = t0;
    wait_done(300, lat);
    check("b2b_lat1", lat, 133);
    d1 = hash_data_out;
    check("b2b_dig1", d1, exp_dig(m_zero, 1'b0));
    start_req(m_xmss, 1'b1);
    hold_bad = 0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hash_done) begin
        lat = cyc - tfirst;
        break;
      end
      if (hash_data_out !== d1) hold_bad++;
    end
    check("b2b_hold", hold_bad, 0);
    check("b2b_lat2", lat, 332);
    check("b2b_dig2", hash_data_out, exp_dig(m_xmss, 1'b1));

    // reset mid-request aborts it
    @(posedge clk); #1;
    dc0 = done_cnt;
    start_req(m_xmss, 1'b1);
    while (cyc - t0 < 70) @(posedge clk);
    #1;
    reset = 1'b1;
    hash_start = 1'b1;
    hash_data_in = m_alt;
    @(posedge clk); #1;
    hash_start = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", hash_done, 0);
    check("abort_dout", hash_data_out, 0);
    reset = 1'b0;
    start_req(m_alt, 1'b0);
    wait_done(300, lat);
    check("abort_new_lat", lat, 133);
    check("abort_new_dig", hash_data_out,
          exp_dig(m_alt, 1'b0));
    @(posedge clk); #1;
    check("abort_done_cnt", done_cnt - dc0, 1);

    // PRF-style chain: 3 x 768-bit then 1 x 1024-bit
    dc0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      start_req(m_ch[k], k == 3);
      wait_done(400, lat);
      check($sformatf("chain%0d_lat", k), lat,
            (k == 3) ? 199 : 133);
      check($sformatf("chain%0d_dig", k), hash_data_out,
            exp_dig(m_ch[k], k == 3));
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("chain_done_cnt", done_cnt - dc0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_xmss_core.md
SHA256_XMSS_CORE -- requirements
Module: sha256_xmss_core

Interface
REQ-001 SHALL have parameter KEY_LEN, default 256, digest width in bits; only 256 is legal.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port hash_start  input  1  one-cycle request pulse from the hash initiator.
REQ-005 SHALL have port hash_data_in  input  1024  message, first message bit at bit 1023.
REQ-006 SHALL have port message_length  input  1  message size: 0 = 768 bits in hash_data_in[1023:256]; 1 = 1024 bits in hash_data_in[1023:0].
REQ-007 SHALL have port hash_done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port hash_data_out  output  KEY_LEN  SHA-256 digest, with H0 in [255:224] and H7 in [31:0].
REQ-009 SHALL have port busy  output  1  high while a request is in progress.

Function
REQ-010 SHALL compute standard FIPS 180-4 SHA-256 of the selected message, including padding, using one compression round per cycle.
REQ-011 SHALL accept hash_start only while busy=0; it samples hash_data_in and message_length into internal registers on that cycle. hash_start while busy=1 SHALL be ignored with no state change.
REQ-012 SHALL build blocks for message_length=0 as: B1 = in[1023:512]; B2 = {in[511:256], 1'b1, 191'b0, 64'd768}.
REQ-013 SHALL build blocks for message_length=1 as: B1 = in[1023:512]; B2 = in[511:0]; B3 = {1'b1, 447'b0, 64'd1024}.
REQ-014 SHALL implement FSM states IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE->LOAD on an accepted start; H0..H7 loaded with the IV.
- LOAD (1 cycle): a..h <- H; W window <- current block.
- ROUND (64 cycles, round counter 0..63; counter wraps to 0 on exit).
- UPDATE (1 cycle): H += a..h (mod 2^32 per word); block index +1; go to LOAD if blocks remain, else DONE.
- DONE (1 cycle) -> IDLE.
REQ-015 SHALL use all arithmetic modulo 2^32 per word; W schedule SHALL be a 16-word sliding window; K SHALL be a 64-entry constant table.
REQ-016 SHALL have latency, with start sampled in cycle 0: hash_done high in cycle 133 for message_length=0 and in cycle 199 for message_length=1, exactly one cycle wide.
REQ-017 SHALL update hash_data_out in the DONE cycle and hold it stable until the next DONE, not only until the next start.
REQ-018 SHALL drive busy to 1 from the cycle after an accepted start through UPDATE, and to 0 in DONE and IDLE. A start in the DONE cycle SHALL be accepted (back-to-back operation).
REQ-019 SHALL NOT let a start coincident with reset have any effect; reset has priority.
REQ-020 SHALL NOT allow message_length or hash_data_in changes after the start cycle to affect the running computation.

Reset
REQ-021 SHALL, while reset=1 at a clock edge: state=IDLE; hash_done=0; busy=0; hash_data_out=0; round counter, block index, W, a..h and H cleared.
REQ-022 SHALL abort any operation when reset is asserted mid-operation, and SHALL NOT raise hash_done for the aborted request.
REQ-023 SHALL accept a new start on the first cycle after reset deasserts.

Verification
REQ-024 SHALL be checked with this scenario: 768-bit all-zero message, message_length=0 -> hash_done at cycle 133; digest equals software SHA-256 of 96 zero bytes.
REQ-025 SHALL be checked with this scenario: 1024-bit message {256'd1, key=256'hAA..AA, addr, 256'd0}, message_length=1 -> hash_done at cycle 199; digest matches software SHA-256 of those 128 bytes.
REQ-026 SHALL be checked with this scenario: start pulses at cycles 10, 50, 100 during a length-0 request started at cycle 0 -> exactly one hash_done, at cycle 133, with the correct digest.
REQ-027 SHALL be checked with this scenario: back-to-back run with second start in the first DONE cycle (cycle 133, length 1) -> second hash_done at cycle 332; first digest held on hash_data_out from cycle 133 to 331.
REQ-028 SHALL be checked with this scenario: reset asserted at cycle 70 of a length-1 request -> from the next cycle busy=0, hash_done=0 and hash_data_out=0; a new length-0 request started immediately afterwards completes 133 cycles later with the correct digest.
REQ-029 SHALL be checked with this scenario: three chained requests emulating three PRF calls plus one core hash (three with length 0, then one with length 1, each started the cycle after the previous hash_done) -> four hash_done pulses; all digests match the reference model.
